// File: rtl/mesi_pkg.sv
// Shared MESI encodings: line states, request ops, bus ops and snoop responses.
package mesi_pkg;

    typedef enum logic [1:0] {
        ST_I = 2'b00,
        ST_S = 2'b01,
        ST_E = 2'b10,
        ST_M = 2'b11
    } mesi_state_t;

    typedef enum logic [2:0] {
        OP_PR_READ       = 3'd0,
        OP_PR_WRITE      = 3'd1,
        OP_PR_IFETCH     = 3'd2,
        OP_SN_INVALIDATE = 3'd3,
        OP_SN_READ       = 3'd4,
        OP_SN_WRITE      = 3'd5,
        OP_SN_RWIM       = 3'd6,
        OP_CLEAR         = 3'd7
    } mesi_op_t;

    typedef enum logic [2:0] {
        BUS_NONE       = 3'd0,
        BUS_READ       = 3'd1,
        BUS_RWIM       = 3'd2,
        BUS_INVALIDATE = 3'd3,
        BUS_WRITEBACK  = 3'd4
    } bus_op_t;

    typedef enum logic [1:0] {
        SNP_NOHIT = 2'd0,
        SNP_HIT   = 2'd1,
        SNP_HITM  = 2'd2
    } snoop_t;

    function automatic logic is_proc_op(mesi_op_t op);
        return (op == OP_PR_READ) || (op == OP_PR_WRITE) || (op == OP_PR_IFETCH);
    endfunction

endpackage

// File: rtl/mesi_next_state.sv
// Combinational MESI transition table for one line: (state, op, shared) ->
// (next state, bus op to issue, snoop response, illegal-op flag).
module mesi_next_state
    import mesi_pkg::*;
(
    input  mesi_state_t old_state_i,
    input  mesi_op_t    op_i,
    input  logic        shared_i,
    output mesi_state_t new_state_o,
    output bus_op_t     bus_op_o,
    output snoop_t      snoop_o,
    output logic        err_o
);

    always_comb begin
        new_state_o = old_state_i;
        bus_op_o    = BUS_NONE;
        snoop_o     = SNP_NOHIT;
        err_o       = 1'b0;
        case (op_i)
            OP_PR_READ, OP_PR_IFETCH: begin
                if (old_state_i == ST_I) begin
                    bus_op_o    = BUS_READ;
                    new_state_o = shared_i ? ST_S : ST_E;
                end
            end
            OP_PR_WRITE: begin
                new_state_o = ST_M;
                if (old_state_i == ST_I)      bus_op_o = BUS_RWIM;
                else if (old_state_i == ST_S) bus_op_o = BUS_INVALIDATE;
            end
            OP_SN_READ, OP_SN_RWIM: begin
                if (old_state_i != ST_I) begin
                    new_state_o = (op_i == OP_SN_READ) ? ST_S : ST_I;
                    snoop_o     = SNP_HIT;
                    if (old_state_i == ST_M) begin
                        snoop_o  = SNP_HITM;
                        bus_op_o = BUS_WRITEBACK;
                    end
                end
            end
            OP_SN_INVALIDATE: begin
                // A foreign invalidate can only target a line we share; E/M is a protocol error.
                if (old_state_i == ST_S) begin
                    new_state_o = ST_I;
                    snoop_o     = SNP_HIT;
                end else if (old_state_i != ST_I) begin
                    err_o = 1'b1;
                end
            end
            OP_SN_WRITE: begin
                if (old_state_i != ST_I) err_o = 1'b1;
            end
            OP_CLEAR: new_state_o = ST_I;
            default: ;
        endcase
    end

endmodule

// File: rtl/mesi_line_array.sv
// MESI state array for NUM_LINES lines: one request per cycle, registered response,
// multi-cycle CLEAR sweep. Define MESI_STATS_EN to build the hit/miss/writeback counters.
module mesi_line_array
    import mesi_pkg::*;
#(
    parameter int NUM_LINES = 16,
    parameter int IDX_W     = $clog2(NUM_LINES),
    parameter int STAT_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [IDX_W-1:0]  req_idx,
    input  logic              req_shared,
    output logic              rsp_valid,
    output logic [1:0]        rsp_old_state,
    output logic [1:0]        rsp_new_state,
    output logic [2:0]        rsp_bus_op,
    output logic [1:0]        rsp_snoop,
    output logic              rsp_err,
    output logic [STAT_W-1:0] stat_hits,
    output logic [STAT_W-1:0] stat_misses,
    output logic [STAT_W-1:0] stat_wbacks
);

    mesi_state_t [NUM_LINES-1:0] lines_q;
    logic                        clearing_q;
    logic [IDX_W-1:0]            sweep_q;

    logic        rsp_valid_q, rsp_err_q;
    mesi_state_t rsp_old_q, rsp_new_q;
    bus_op_t     rsp_bus_q;
    snoop_t      rsp_snoop_q;

    mesi_op_t    op;
    mesi_state_t old_st, new_st;
    bus_op_t     bus_d;
    snoop_t      snoop_d;
    logic        err_d, accept;

    assign op        = mesi_op_t'(req_op);
    assign old_st    = lines_q[req_idx];
    assign req_ready = !clearing_q;
    assign accept    = req_valid && req_ready;

    mesi_next_state u_next (
        .old_state_i (old_st),
        .op_i        (op),
        .shared_i    (req_shared),
        .new_state_o (new_st),
        .bus_op_o    (bus_d),
        .snoop_o     (snoop_d),
        .err_o       (err_d)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_LINES; i++) lines_q[i] <= ST_I;
            clearing_q  <= 1'b0;
            sweep_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_old_q   <= ST_I;
            rsp_new_q   <= ST_I;
            rsp_bus_q   <= BUS_NONE;
            rsp_snoop_q <= SNP_NOHIT;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            if (clearing_q) begin
                lines_q[sweep_q] <= ST_I;
                if (sweep_q == IDX_W'(NUM_LINES - 1)) begin
                    clearing_q  <= 1'b0;
                    sweep_q     <= '0;
                    rsp_valid_q <= 1'b1;
                    rsp_old_q   <= ST_I;
                    rsp_new_q   <= ST_I;
                    rsp_bus_q   <= BUS_NONE;
                    rsp_snoop_q <= SNP_NOHIT;
                    rsp_err_q   <= 1'b0;
                end else begin
                    sweep_q <= sweep_q + 1'b1;
                end
            end else if (accept) begin
                if (op == OP_CLEAR) begin
                    clearing_q <= 1'b1;
                end else begin
                    lines_q[req_idx] <= new_st;
                    rsp_valid_q      <= 1'b1;
                    rsp_old_q        <= old_st;
                    rsp_new_q        <= new_st;
                    rsp_bus_q        <= bus_d;
                    rsp_snoop_q      <= snoop_d;
                    rsp_err_q        <= err_d;
                end
            end
        end
    end

    assign rsp_valid     = rsp_valid_q;
    assign rsp_old_state = rsp_old_q;
    assign rsp_new_state = rsp_new_q;
    assign rsp_bus_op    = rsp_bus_q;
    assign rsp_snoop     = rsp_snoop_q;
    assign rsp_err       = rsp_err_q;

`ifdef MESI_STATS_EN
    logic [STAT_W-1:0] hits_q, misses_q, wbacks_q;
    logic              proc_acc;

    assign proc_acc = accept && is_proc_op(op);

    // Counters saturate at all-ones and survive CLEAR; only reset zeroes them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hits_q   <= '0;
            misses_q <= '0;
            wbacks_q <= '0;
        end else begin
            if (proc_acc && old_st != ST_I && !(&hits_q))   hits_q   <= hits_q + 1'b1;
            if (proc_acc && old_st == ST_I && !(&misses_q)) misses_q <= misses_q + 1'b1;
            if (accept && bus_d == BUS_WRITEBACK && !(&wbacks_q)) wbacks_q <= wbacks_q + 1'b1;
        end
    end

    assign stat_hits   = hits_q;
    assign stat_misses = misses_q;
    assign stat_wbacks = wbacks_q;
`else
    assign stat_hits   = '0;
    assign stat_misses = '0;
    assign stat_wbacks = '0;
`endif

endmodule

// File: tb/tb_mesi_line_array.sv
// Scoreboard bench for mesi_line_array: directed MESI transitions, random back-to-back
// traffic against a table model, CLEAR sweep timing and async reset mid-operation.
module tb_mesi_line_array;

    localparam int N  = 16;
    localparam int IW = 4;
    localparam int SW = 32;

    localparam logic [2:0] PR_RD = 3'd0, PR_WR = 3'd1, PR_IF = 3'd2, SN_INV = 3'd3,
                           SN_RD = 3'd4, SN_WR = 3'd5, SN_RWIM = 3'd6, CLR = 3'd7;
    localparam logic [1:0] SI = 2'd0, SS = 2'd1, SE = 2'd2, SM = 2'd3;
    localparam logic [2:0] B_NONE = 3'd0, B_READ = 3'd1, B_RWIM = 3'd2, B_INV = 3'd3, B_WB = 3'd4;
    localparam logic [1:0] NOH = 2'd0, HIT = 2'd1, HITM = 2'd2;

    typedef struct {
        logic [1:0] old_s;
        logic [1:0] new_s;
        logic [2:0] bus;
        logic [1:0] snp;
        logic       err;
    } exp_t;

    logic          clk = 1'b0, reset = 1'b1;
    logic          req_valid = 1'b0, req_ready, req_shared = 1'b0;
    logic [2:0]    req_op = 3'd0;
    logic [IW-1:0] req_idx = '0;
    logic          rsp_valid, rsp_err;
    logic [1:0]    rsp_old_state, rsp_new_state, rsp_snoop;
    logic [2:0]    rsp_bus_op;
    logic [SW-1:0] stat_hits, stat_misses, stat_wbacks;

    exp_t       sbq[$];
    int         checks = 0, failures = 0, rsp_seen = 0;
    logic [1:0] mline[N];
    int         m_hits = 0, m_miss = 0, m_wb = 0;

    mesi_line_array dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_idx(req_idx), .req_shared(req_shared),
        .rsp_valid(rsp_valid), .rsp_old_state(rsp_old_state), .rsp_new_state(rsp_new_state),
        .rsp_bus_op(rsp_bus_op), .rsp_snoop(rsp_snoop), .rsp_err(rsp_err),
        .stat_hits(stat_hits), .stat_misses(stat_misses), .stat_wbacks(stat_wbacks)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(logic [1:0] o, logic [1:0] n, logic [2:0] b, logic [1:0] s, logic e);
        exp_t r;
        r.old_s = o; r.new_s = n; r.bus = b; r.snp = s; r.err = e;
        return r;
    endfunction

    function automatic exp_t model_op(logic [2:0] op, logic [1:0] st, logic sh);
        exp_t r;
        r = mk(st, st, B_NONE, NOH, 1'b0);
        case (op)
            PR_RD, PR_IF: if (st == SI) begin r.bus = B_READ; r.new_s = sh ? SS : SE; end
            PR_WR: begin
                r.new_s = SM;
                if (st == SI) r.bus = B_RWIM;
                else if (st == SS) r.bus = B_INV;
            end
            SN_RD: if (st == SM) begin r.snp = HITM; r.bus = B_WB; r.new_s = SS; end
                   else if (st != SI) begin r.snp = HIT; r.new_s = SS; end
            SN_RWIM: if (st == SM) begin r.snp = HITM; r.bus = B_WB; r.new_s = SI; end
                     else if (st != SI) begin r.snp = HIT; r.new_s = SI; end
            SN_INV: if (st == SS) begin r.snp = HIT; r.new_s = SI; end
                    else if (st != SI) r.err = 1'b1;
            SN_WR: if (st != SI) r.err = 1'b1;
            default: ;
        endcase
        return r;
    endfunction

    function automatic int xh();
`ifdef MESI_STATS_EN
        return m_hits;
`else
        return 0;
`endif
    endfunction
    function automatic int xm();
`ifdef MESI_STATS_EN
        return m_miss;
`else
        return 0;
`endif
    endfunction
    function automatic int xw();
`ifdef MESI_STATS_EN
        return m_wb;
`else
        return 0;
`endif
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) mline[i] = SI;
        m_hits = 0; m_miss = 0; m_wb = 0;
    endfunction

    // Drive one request (accepted on the following rising edge) and queue its expected response.
    task automatic send(input logic [2:0] op, input int idx, input logic sh, input exp_t e);
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL send_ready op=%0d idx=%0d got req_ready=%b want 1", op, idx, req_ready);
        end
        req_valid = 1'b1; req_op = op; req_idx = idx[IW-1:0]; req_shared = sh;
        sbq.push_back(e);
        if (op == CLR) begin
            for (int i = 0; i < N; i++) mline[i] = SI;
        end else begin
            if (op == PR_RD || op == PR_WR || op == PR_IF) begin
                if (e.old_s == SI) m_miss++; else m_hits++;
            end
            if (e.bus == B_WB) m_wb++;
            mline[idx] = e.new_s;
        end
    endtask

    task automatic idle();
        @(negedge clk);
        req_valid = 1'b0;
        #1;
    endtask

    task automatic probe_all_i();
        for (int i = 0; i < N; i++) send(SN_WR, i, 1'b0, mk(SI, SI, B_NONE, NOH, 1'b0));
        idle();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset && rsp_valid) begin
            rsp_seen++;
            checks++;
            if (sbq.size() == 0) begin
                failures++;
                $display("FAIL rsp_unexpected got old=%0d new=%0d bus=%0d", rsp_old_state, rsp_new_state, rsp_bus_op);
            end else begin
                e = sbq.pop_front();
                if ({rsp_old_state, rsp_new_state, rsp_bus_op, rsp_snoop, rsp_err} !==
                    {e.old_s, e.new_s, e.bus, e.snp, e.err}) begin
                    failures++;
                    $display("FAIL rsp got old=%0d new=%0d bus=%0d snp=%0d err=%0d want old=%0d new=%0d bus=%0d snp=%0d err=%0d",
                             rsp_old_state, rsp_new_state, rsp_bus_op, rsp_snoop, rsp_err,
                             e.old_s, e.new_s, e.bus, e.snp, e.err);
                end
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        model_reset();
        #3;
        checks++;
        if ({req_ready, rsp_valid, rsp_old_state, rsp_new_state, rsp_bus_op, rsp_snoop, rsp_err} !== 12'h800) begin
            failures++;
            $display("FAIL reset_outputs got rdy=%b vld=%b old=%0d new=%0d bus=%0d snp=%0d err=%b",
                     req_ready, rsp_valid, rsp_old_state, rsp_new_state, rsp_bus_op, rsp_snoop, rsp_err);
        end
        checks++;
        if ({stat_hits, stat_misses, stat_wbacks} !== '0) begin
            failures++;
            $display("FAIL reset_stats got h=%0d m=%0d w=%0d want 0", stat_hits, stat_misses, stat_wbacks);
        end
        @(negedge clk);
        reset = 1'b0;
        probe_all_i();
    endtask

    task automatic test_proc_read();
        send(PR_RD, 3, 1'b0, mk(SI, SE, B_READ, NOH, 1'b0));
        send(PR_RD, 3, 1'b0, mk(SE, SE, B_NONE, NOH, 1'b0));
        send(PR_RD, 5, 1'b1, mk(SI, SS, B_READ, NOH, 1'b0));
        send(PR_WR, 5, 1'b0, mk(SS, SM, B_INV, NOH, 1'b0));
        send(SN_RD, 5, 1'b0, mk(SM, SS, B_WB, HITM, 1'b0));
        idle();
        checks++;
        if (stat_hits !== SW'(xh()) || stat_misses !== SW'(xm()) || stat_wbacks !== SW'(xw())) begin
            failures++;
            $display("FAIL stats_read got h=%0d m=%0d w=%0d want h=%0d m=%0d w=%0d",
                     stat_hits, stat_misses, stat_wbacks, xh(), xm(), xw());
        end
    endtask

    task automatic test_write_snoop();
        send(PR_WR, 0, 1'b0, mk(SI, SM, B_RWIM, NOH, 1'b0));
        send(SN_RWIM, 0, 1'b0, mk(SM, SI, B_WB, HITM, 1'b0));
        send(SN_INV, 3, 1'b0, mk(SE, SE, B_NONE, NOH, 1'b1));
        send(SN_WR, 3, 1'b0, mk(SE, SE, B_NONE, NOH, 1'b1));
        send(SN_WR, 7, 1'b0, mk(SI, SI, B_NONE, NOH, 1'b0));
        send(SN_INV, 5, 1'b0, mk(SS, SI, B_NONE, HIT, 1'b0));
        send(PR_IF, 5, 1'b1, mk(SI, SS, B_READ, NOH, 1'b0));
        send(SN_RWIM, 5, 1'b0, mk(SS, SI, B_NONE, HIT, 1'b0));
        send(SN_RD, 3, 1'b0, mk(SE, SS, B_NONE, HIT, 1'b0));
        idle();
        checks++;
        if (stat_hits !== SW'(xh()) || stat_misses !== SW'(xm()) || stat_wbacks !== SW'(xw())) begin
            failures++;
            $display("FAIL stats_write got h=%0d m=%0d w=%0d want h=%0d m=%0d w=%0d",
                     stat_hits, stat_misses, stat_wbacks, xh(), xm(), xw());
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 80; k++) begin
            logic [2:0] op;
            int         idx;
            logic       sh;
            op  = 3'($urandom_range(0, 6));
            idx = $urandom_range(0, 3);
            sh  = 1'($urandom_range(0, 1));
            send(op, idx, sh, model_op(op, mline[idx], sh));
        end
        idle();
        checks++;
        if (stat_hits !== SW'(xh()) || stat_misses !== SW'(xm()) || stat_wbacks !== SW'(xw())) begin
            failures++;
            $display("FAIL stats_b2b got h=%0d m=%0d w=%0d want h=%0d m=%0d w=%0d",
                     stat_hits, stat_misses, stat_wbacks, xh(), xm(), xw());
        end
    endtask

    task automatic test_clear();
        int low, seen0;
        for (int i = 0; i < 8; i++) send(PR_WR, i, 1'b0, model_op(PR_WR, mline[i], 1'b0));
        send(CLR, 0, 1'b0, mk(SI, SI, B_NONE, NOH, 1'b0));
        seen0 = rsp_seen + 1;  // the last PR_WR response is popped on the next falling edge
        @(negedge clk);
        req_valid = 1'b0;
        low = 0;
        while (req_ready !== 1'b1 && low < 100) begin
            low++;
            @(negedge clk);
        end
        #1;
        checks++;
        if (low != N) begin
            failures++;
            $display("FAIL clear_ready_low got %0d cycles want %0d", low, N);
        end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_seen - seen0 != 1) begin
            failures++;
            $display("FAIL clear_rsp got vld=%b count=%0d want vld=1 count=1", rsp_valid, rsp_seen - seen0);
        end
        probe_all_i();
        checks++;
        if (stat_hits !== SW'(xh()) || stat_misses !== SW'(xm()) || stat_wbacks !== SW'(xw())) begin
            failures++;
            $display("FAIL stats_clear got h=%0d m=%0d w=%0d want h=%0d m=%0d w=%0d",
                     stat_hits, stat_misses, stat_wbacks, xh(), xm(), xw());
        end
    endtask

    task automatic test_reset_mid();
        // Reset in the middle of a CLEAR sweep.
        send(PR_WR, 2, 1'b0, model_op(PR_WR, mline[2], 1'b0));
        send(PR_WR, 9, 1'b0, model_op(PR_WR, mline[9], 1'b0));
        send(CLR, 0, 1'b0, mk(SI, SI, B_NONE, NOH, 1'b0));
        @(negedge clk);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_old_state, rsp_new_state, rsp_bus_op, rsp_snoop, rsp_err} !== 12'h800 ||
            {stat_hits, stat_misses, stat_wbacks} !== '0) begin
            failures++;
            $display("FAIL reset_mid_clear got rdy=%b vld=%b old=%0d new=%0d bus=%0d h=%0d",
                     req_ready, rsp_valid, rsp_old_state, rsp_new_state, rsp_bus_op, stat_hits);
        end
        sbq.delete();
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        probe_all_i();
        // Reset while a response is still being presented.
        send(PR_WR, 1, 1'b0, mk(SI, SM, B_RWIM, NOH, 1'b0));
        send(PR_RD, 1, 1'b0, mk(SM, SM, B_NONE, NOH, 1'b0));
        @(negedge clk);
        req_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_old_state, rsp_new_state, rsp_bus_op, rsp_snoop, rsp_err} !== 12'h800 ||
            {stat_hits, stat_misses, stat_wbacks} !== '0) begin
            failures++;
            $display("FAIL reset_mid_stream got rdy=%b vld=%b old=%0d new=%0d bus=%0d h=%0d",
                     req_ready, rsp_valid, rsp_old_state, rsp_new_state, rsp_bus_op, stat_hits);
        end
        sbq.delete();
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        probe_all_i();
    endtask

    initial begin
        test_reset();
        test_proc_read();
        test_write_snoop();
        test_back_to_back();
        test_clear();
        test_reset_mid();
        repeat (2) @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL missing_rsp got %0d outstanding want 0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mesi_line_array.md
# mesi_line_array

Parametrised MESI coherence controller for the cache simulator: holds the MESI state of NUM_LINES cache lines and applies one processor or snooped bus operation per accepted request. For each request it reports old/new state, the bus operation this cache must issue, and the snoop result it must drive. It generalises the single-line I/S/E/M machine to an indexed line array with shared-signal input, snoop responses, a multi-cycle CLEAR sweep and optional statistics.

## Interface
- NUM_LINES, 16: lines tracked; power of two, >= 2
- IDX_W, $clog2(NUM_LINES): line index width (derived)
- STAT_W, 32: statistics counter width
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request can be accepted this cycle
- req_op  in  3  0 PR_READ, 1 PR_WRITE, 2 PR_IFETCH, 3 SN_INVALIDATE, 4 SN_READ, 5 SN_WRITE, 6 SN_RWIM, 7 CLEAR
- req_idx  in  IDX_W  target line (ignored for CLEAR)
- req_shared  in  1  another cache reported HIT/HITM on our bus READ; sampled with the request
- rsp_valid  out  1  one-cycle response pulse
- rsp_old_state, rsp_new_state  out  2  I=00, S=01, E=10, M=11
- rsp_bus_op  out  3  0 NONE, 1 READ, 2 RWIM, 3 INVALIDATE, 4 WRITEBACK
- rsp_snoop  out  2  0 NOHIT, 1 HIT, 2 HITM
- rsp_err  out  1  illegal operation for current state
- stat_hits, stat_misses, stat_wbacks  out  STAT_W  counters (see Configuration)

## Operation
- Accept = req_valid && req_ready at rising clk; line state read combinationally at accept, written on same edge.
- PR_READ / PR_IFETCH: I -> bus READ, new S if req_shared else E (miss); S/E/M unchanged, NONE (hit).
- PR_WRITE: I -> RWIM, M (miss); S -> INVALIDATE, M (hit); E -> M, NONE (hit); M -> M, NONE (hit).
- SN_READ: M -> HITM, WRITEBACK, S; E -> HIT, S; S -> HIT, S; I -> NOHIT, I.
- SN_RWIM: M -> HITM, WRITEBACK, I; E/S -> HIT, I; I -> NOHIT, I.
- SN_INVALIDATE: S -> I, HIT; I -> I, NOHIT; E/M -> rsp_err=1, state unchanged, NOHIT.
- SN_WRITE: I -> NOHIT, no change; any other state -> rsp_err=1, state unchanged.
- CLEAR: sweeps lines 0..NUM_LINES-1, one per cycle, to I; req_ready low for the whole sweep; single response after last line with old/new = I, NONE, NOHIT.
- Snoops never counted as hits/misses; rsp_err never changes state.

## Timing
- Reset (async): all lines I, req_ready=1, rsp_valid=0, all rsp_* =0, sweep counter 0, stats 0.
- Non-CLEAR latency: response registered, rsp_valid high exactly one cycle after accept; back-to-back accepts every cycle.
- Back-to-back same index: second request sees state written by the first.
- CLEAR: accepted at edge T, lines cleared at edges T+1..T+NUM_LINES, rsp_valid high in cycle after T+NUM_LINES, req_ready returns 1 same cycle as rsp_valid.
- Reset during CLEAR aborts sweep; array is all I regardless.
- rsp_* hold last values when rsp_valid=0.

## Configuration
- MESI_STATS_EN defined: stat_hits/stat_misses increment on processor hit/miss, stat_wbacks on every WRITEBACK response; saturate at all-ones; cleared by reset only (not CLEAR).
- Undefined: counter logic absent, stat_* tied to 0; ports remain.

## Structure
- mesi_pkg: mesi_state_t, mesi_op_t, bus_op_t, snoop_t enums and their encodings.
- Sub-module mesi_next_state: combinational (old state, op, shared) -> (new state, bus op, snoop, err); instantiated once in mesi_line_array.

## Test plan
- After reset: PR_READ idx 3, shared=0 -> old I, new E, bus READ; repeat -> E, NONE, hit count 1.
- PR_READ idx 5 shared=1 -> S; PR_WRITE idx 5 -> S->M, INVALIDATE; SN_READ idx 5 -> HITM, WRITEBACK, M->S, stat_wbacks=1.
- PR_WRITE idx 0 from I -> RWIM, M; SN_RWIM idx 0 -> HITM, WRITEBACK, I.
- SN_INVALIDATE on E line -> rsp_err=1, state stays E; SN_WRITE on I -> NOHIT, no err.
- Fill several lines, CLEAR with NUM_LINES=16 -> req_ready low 16 cycles, one rsp_valid, every line reads I afterwards.
- Assert reset mid-CLEAR and mid-stream -> all outputs at reset values immediately, all lines I.
